block_fetch_2x2: RTL and testbench

//  Upstream feeder for the zoom-out block-averaging stage. It fetches the 2x2

---
 rtl/block_fetch_2x2.sv | 223 ++++++++++++++++++++++
 tb/tb_block_fetch_2x2.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/block_fetch_2x2.sv
// 2x2 neighbourhood fetcher: issues up to four single-port reads per request,
// captures the tagged read data and presents TL/TR/BL/BR with a valid/ready handshake.
module block_fetch_2x2 #(
  parameter int IMG_WIDTH   = 160,
  parameter int IMG_HEIGHT  = 120,
  parameter int ADDR_W      = 15,
  parameter int PIX_W       = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_x,
  input  logic [6:0]        req_y,
  input  logic              req_single,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  pixel_p0,
  output logic [PIX_W-1:0]  pixel_p1,
  output logic [PIX_W-1:0]  pixel_p2,
  output logic [PIX_W-1:0]  pixel_p3,
  output logic              out_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] X_MAX = 8'(IMG_WIDTH - 1);
  localparam logic [6:0] Y_MAX = 7'(IMG_HEIGHT - 1);

  function automatic logic [ADDR_W-1:0] f_addr(input logic [7:0] x, input logic [6:0] y);
    f_addr = ADDR_W'(y) * ADDR_W'(IMG_WIDTH) + ADDR_W'(x);
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_req_ready;
  logic               r_rd_en;
  logic               w_rd_en_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [ADDR_W-1:0]  w_seq_addr;
  logic [1:0]         r_cnt;
  logic [1:0]         w_cnt_nxt;
  logic               r_out_valid;
  logic               w_out_valid_nxt;
  logic               w_load;
  logic               r_single;
  logic               r_err;
  logic [7:0]         r_x;
  logic [7:0]         r_x1;
  logic [6:0]         r_y;
  logic [6:0]         r_y1;
  logic [7:0]         w_cx;
  logic [6:0]         w_cy;
  logic               w_err;
  logic [1:0]         w_last_tag;
  logic               w_cap_vld;
  logic [1:0]         w_cap_tag;
  logic               r_pipe_vld [MEM_LATENCY];
  logic [1:0]         r_pipe_tag [MEM_LATENCY];
  logic [PIX_W-1:0]   r_pix      [4];

  // Clamp out-of-range request coordinates before any address math
  always_comb begin
    w_cx  = (req_x > X_MAX) ? X_MAX : req_x;
    w_cy  = (req_y > Y_MAX) ? Y_MAX : req_y;
    w_err = (req_x > X_MAX) || (req_y > Y_MAX);
  end

  // Address of the next read in TL, TR, BL, BR order
  always_comb begin
    w_seq_addr = f_addr(r_x, r_y);
    case (r_cnt + 2'd1)
      2'd1:    w_seq_addr = f_addr(r_x1, r_y);
      2'd2:    w_seq_addr = f_addr(r_x, r_y1);
      2'd3:    w_seq_addr = f_addr(r_x1, r_y1);
      default: w_seq_addr = f_addr(r_x, r_y);
    endcase
  end

  assign w_cap_vld  = r_pipe_vld[MEM_LATENCY-1];
  assign w_cap_tag  = r_pipe_tag[MEM_LATENCY-1];
  assign w_last_tag = r_single ? 2'd0 : 2'd3;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_rd_en_nxt     = 1'b0;
    w_addr_nxt      = r_addr;
    w_cnt_nxt       = r_cnt;
    w_out_valid_nxt = r_out_valid;
    w_load          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_nxt = S_ISSUE;
          w_rd_en_nxt = 1'b1;
          w_addr_nxt  = f_addr(w_cx, w_cy);
          w_cnt_nxt   = 2'd0;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (r_single || (r_cnt == 2'd3)) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_cnt_nxt   = r_cnt + 2'd1;
          w_rd_en_nxt = 1'b1;
          w_addr_nxt  = w_seq_addr;
        end
      end
      S_DRAIN: begin
        if (w_cap_vld && (w_cap_tag == w_last_tag)) begin
          w_state_nxt     = S_HOLD;
          w_out_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, strobe and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rd_en     <= 1'b0;
      r_addr      <= '0;
      r_cnt       <= 2'd0;
      r_out_valid <= 1'b0;
      r_single    <= 1'b0;
      r_err       <= 1'b0;
      r_x         <= 8'd0;
      r_x1        <= 8'd0;
      r_y         <= 7'd0;
      r_y1        <= 7'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_rd_en     <= w_rd_en_nxt;
      r_addr      <= w_addr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (w_load) begin
        r_single <= req_single;
        r_err    <= w_err;
        r_x      <= w_cx;
        r_y      <= w_cy;
        r_x1     <= (w_cx == X_MAX) ? w_cx : w_cx + 8'd1;
        r_y1     <= (w_cy == Y_MAX) ? w_cy : w_cy + 7'd1;
      end
    end
  end

  // Tag pipe: the slot of each read travels alongside the memory latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        r_pipe_vld[i] <= 1'b0;
        r_pipe_tag[i] <= 2'd0;
      end
    end else begin
      r_pipe_vld[0] <= r_rd_en;
      r_pipe_tag[0] <= r_cnt;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

  // Pixel slots; single mode replicates the one read into every slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_pix[i] <= '0;
      end
    end else if (w_cap_vld) begin
      if (r_single) begin
        for (int i = 0; i < 4; i++) begin
          r_pix[i] <= mem_rdata;
        end
      end else begin
        r_pix[w_cap_tag] <= mem_rdata;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign mem_rd_en = r_rd_en;
  assign mem_addr  = r_addr;
  assign out_valid = r_out_valid;
  assign out_err   = r_err;
  assign pixel_p0  = r_pix[0];
  assign pixel_p1  = r_pix[1];
  assign pixel_p2  = r_pix[2];
  assign pixel_p3  = r_pix[3];

endmodule

// File: tb/tb_block_fetch_2x2.sv
// Directed bench for block_fetch_2x2: one instance at memory latency 1, one at 2,
// each backed by a memory model returning mem[a] = a[7:0].
module tb_block_fetch_2x2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rv_a = 1'b0;
  logic        rv_b = 1'b0;
  logic [7:0]  req_x = 8'd0;
  logic [6:0]  req_y = 7'd0;
  logic        req_single = 1'b0;
  logic        out_ready = 1'b0;
  logic        sel = 1'b0;

  logic        rr_a, rd_a, ov_a, er_a, rr_b, rd_b, ov_b, er_b;
  logic [14:0] ad_a, ad_b;
  logic [7:0]  md_a, md_b, md_b1;
  logic [7:0]  p0_a, p1_a, p2_a, p3_a, p0_b, p1_b, p2_b, p3_b;

  int n_checks = 0;
  int n_errors = 0;
  int got_addr [8];
  int n_addr;
  int lat;

  always #5 clk = ~clk;

  block_fetch_2x2 #(.MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_a), .req_ready(rr_a),
    .req_x(req_x), .req_y(req_y), .req_single(req_single),
    .mem_rd_en(rd_a), .mem_addr(ad_a), .mem_rdata(md_a),
    .out_valid(ov_a), .out_ready(out_ready),
    .pixel_p0(p0_a), .pixel_p1(p1_a), .pixel_p2(p2_a), .pixel_p3(p3_a),
    .out_err(er_a));

  block_fetch_2x2 #(.MEM_LATENCY(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_b), .req_ready(rr_b),
    .req_x(req_x), .req_y(req_y), .req_single(req_single),
    .mem_rd_en(rd_b), .mem_addr(ad_b), .mem_rdata(md_b),
    .out_valid(ov_b), .out_ready(out_ready),
    .pixel_p0(p0_b), .pixel_p1(p1_b), .pixel_p2(p2_b), .pixel_p3(p3_b),
    .out_err(er_b));

  // Memory models; 8'hEE marks data for a cycle with no read
  always @(posedge clk) begin
    md_a  <= rd_a ? ad_a[7:0] : 8'hEE;
    md_b1 <= rd_b ? ad_b[7:0] : 8'hEE;
    md_b  <= md_b1;
  end

  wire        o_rd  = sel ? rd_b : rd_a;
  wire [14:0] o_ad  = sel ? ad_b : ad_a;
  wire        o_ov  = sel ? ov_b : ov_a;
  wire        o_rr  = sel ? rr_b : rr_a;
  wire        o_er  = sel ? er_b : er_a;
  wire [31:0] o_pix = sel ? {p0_b, p1_b, p2_b, p3_b} : {p0_a, p1_a, p2_a, p3_a};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request on the selected instance, log read addresses and latency
  task automatic do_req(input logic s, input logic [7:0] x, input logic [6:0] y, input logic single);
    sel = s;
    n_addr = 0;
    lat = -1;
    @(negedge clk);
    req_x = x; req_y = y; req_single = single;
    if (s) rv_b = 1'b1; else rv_a = 1'b1;
    @(posedge clk);
    #1;
    rv_a = 1'b0; rv_b = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (o_rd) begin
        if (n_addr < 8) got_addr[n_addr] = int'(o_ad);
        n_addr++;
      end
      if (o_ov) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ov_drop", {31'd0, o_ov}, 32'd0);
    check_eq("idle_ready", {31'd0, o_rr}, 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int bad;
    int stray;
    logic [31:0] held;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'd0, rr_a}, 32'd1);
    check_eq("rst_outs", {28'd0, ov_a, rd_a, er_a, ov_b}, 32'd0);
    check_eq("rst_addr", {17'd0, ad_a}, 32'd0);
    check_eq("rst_pix", {p0_a, p1_a, p2_a, p3_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: reset asserted mid-ISSUE
    sel = 1'b0;
    @(negedge clk);
    req_x = 8'd10; req_y = 7'd5; req_single = 1'b0; rv_a = 1'b1;
    @(posedge clk);
    #1;
    rv_a = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mid_issue_rd", {31'd0, rd_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_outs", {29'd0, ov_a, rd_a, er_a}, 32'd0);
    check_eq("abort_addr", {17'd0, ad_a}, 32'd0);
    check_eq("abort_ready", {31'd0, rr_a}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (rd_a || ov_a || !rr_a) stray++;
    end
    check_eq("abort_quiet", stray, 32'd0);
    check_eq("abort_pix", {p0_a, p1_a, p2_a, p3_a}, 32'd0);

    // Test 2: interior fetch
    do_req(1'b0, 8'd10, 7'd5, 1'b0);
    check_eq("int_lat", lat, 32'd5);
    check_eq("int_nrd", n_addr, 32'd4);
    check_eq("int_a0", got_addr[0], 32'd810);
    check_eq("int_a1", got_addr[1], 32'd811);
    check_eq("int_a2", got_addr[2], 32'd970);
    check_eq("int_a3", got_addr[3], 32'd971);
    check_eq("int_pix", o_pix, 32'h2A2BCACB);
    check_eq("int_err", {31'd0, o_er}, 32'd0);
    check_eq("int_busy", {31'd0, o_rr}, 32'd0);
    release_out();

    // Test 3: bottom-right corner, out_ready held high
    @(negedge clk);
    out_ready = 1'b1;
    do_req(1'b0, 8'd159, 7'd119, 1'b0);
    check_eq("cor_lat", lat, 32'd5);
    check_eq("cor_nrd", n_addr, 32'd4);
    check_eq("cor_a0", got_addr[0], 32'd19199);
    check_eq("cor_a3", got_addr[3], 32'd19199);
    check_eq("cor_pix", o_pix, 32'hFFFFFFFF);
    check_eq("cor_err", {31'd0, o_er}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("cor_hs1", {30'd0, o_ov, o_rr}, 32'd1);
    out_ready = 1'b0;

    // Test 4: out-of-range column is clamped
    do_req(1'b0, 8'd200, 7'd3, 1'b0);
    check_eq("oor_a0", got_addr[0], 32'd639);
    check_eq("oor_a1", got_addr[1], 32'd639);
    check_eq("oor_a2", got_addr[2], 32'd799);
    check_eq("oor_a3", got_addr[3], 32'd799);
    check_eq("oor_pix", o_pix, 32'h7F7F1F1F);
    check_eq("oor_err", {31'd0, o_er}, 32'd1);
    release_out();

    // Test 5: backpressure with a competing request while busy
    do_req(1'b0, 8'd20, 7'd2, 1'b0);
    check_eq("bp_lat", lat, 32'd5);
    check_eq("bp_pix", o_pix, 32'h5455F4F5);
    held = o_pix;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rv_a = 1'b1;
      req_x = 8'd1; req_y = 7'd1;
      @(posedge clk);
      #1;
      if (o_pix !== held || o_rr || o_rd || !o_ov) bad++;
    end
    check_eq("bp_stable", bad, 32'd0);
    @(negedge clk);
    rv_a = 1'b0;
    release_out();
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (o_ov || o_rd || !o_rr) stray++;
    end
    check_eq("bp_one_xfer", stray, 32'd0);

    // Test 6: single-pixel fetch at latency 2
    do_req(1'b1, 8'd0, 7'd1, 1'b1);
    check_eq("sgl_lat", lat, 32'd3);
    check_eq("sgl_nrd", n_addr, 32'd1);
    check_eq("sgl_a0", got_addr[0], 32'd160);
    check_eq("sgl_pix", o_pix, 32'hA0A0A0A0);
    release_out();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
